// File: rtl/execution_pipeline.sv
// SimpleRISC EX stage with EX/MA register: ALU, compare flags, branch resolution.
// One-cycle latency to the registered outputs; no stall or flush, branch outputs are combinational.
module execution_pipeline (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] branchTarget,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] op2,
  input  logic [31:0] instruction,
  input  logic [31:0] control,
  output logic [31:0] pc_out,
  output logic [31:0] aluResult_out,
  output logic [31:0] op2_out,
  output logic [31:0] instruction_out,
  output logic [31:0] control_out,
  output logic [31:0] branch,
  output logic        isBranchTaken
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic        e_q, e_d;
  logic        gt_q, gt_d;

  logic [4:0]         shamt;
  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [32:0] quot;
  logic signed [32:0] rem;

  // 33-bit operands keep 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
  always_comb begin
    shamt = B[4:0];
    a_ext = {A[31], A};
    b_ext = (B == 32'd0) ? 33'sd1 : {B[31], B};
    quot  = a_ext / b_ext;
    rem   = a_ext % b_ext;
  end

  // Lowest-numbered set ALU bit selects the operation.
  always_comb begin
    alu_d = 32'd0;
    if (control[0])       alu_d = A + B;
    else if (control[1])  alu_d = A - B;
    else if (control[2])  alu_d = 32'd0;
    else if (control[3])  alu_d = A * B;
    else if (control[4])  alu_d = (B == 32'd0) ? 32'd0 : quot[31:0];
    else if (control[5])  alu_d = (B == 32'd0) ? 32'd0 : rem[31:0];
    else if (control[6])  alu_d = A & B;
    else if (control[7])  alu_d = A | B;
    else if (control[8])  alu_d = ~A;
    else if (control[9])  alu_d = B;
    else if (control[10]) alu_d = A << shamt;
    else if (control[11]) alu_d = A >> shamt;
    else if (control[12]) alu_d = $signed(A) >>> shamt;
    else if (control[13] || control[14]) alu_d = A + B;
  end

  always_comb begin
    pc_d    = pc;
    op2_d   = op2;
    instr_d = instruction;
    ctrl_d  = control;
    e_d     = e_q;
    gt_d    = gt_q;
    if (control[2]) begin
      e_d  = (A == B);
      gt_d = ($signed(A) > $signed(B));
    end
  end

  // Branch sees the flags as they stand before this instruction's own compare.
  always_comb begin
    branch        = control[18] ? A : branchTarget;
    isBranchTaken = !rst && (control[17] || (control[15] && e_q) || (control[16] && gt_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'd0;
      alu_q   <= 32'd0;
      op2_q   <= 32'd0;
      instr_q <= 32'd0;
      ctrl_q  <= 32'd0;
      e_q     <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      op2_q   <= op2_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
      e_q     <= e_d;
      gt_q    <= gt_d;
    end
  end

  assign pc_out          = pc_q;
  assign aluResult_out   = alu_q;
  assign op2_out         = op2_q;
  assign instruction_out = instr_q;
  assign control_out     = ctrl_q;

endmodule

// File: tb/tb_execution_pipeline.sv
// Scoreboard bench for execution_pipeline: directed corners plus randomized traffic.
module tb_execution_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0, branchTarget = '0, A = '0, B = '0, op2 = '0;
  logic [31:0] instruction = '0, control = '0;
  logic [31:0] pc_out, aluResult_out, op2_out, instruction_out, control_out, branch;
  logic        isBranchTaken;

  execution_pipeline dut (
    .clk(clk), .rst(rst), .pc(pc), .branchTarget(branchTarget), .A(A), .B(B),
    .op2(op2), .instruction(instruction), .control(control),
    .pc_out(pc_out), .aluResult_out(aluResult_out), .op2_out(op2_out),
    .instruction_out(instruction_out), .control_out(control_out),
    .branch(branch), .isBranchTaken(isBranchTaken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] op2;
    logic [31:0] instr;
    logic [31:0] ctrl;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   passed = 0;
  bit   m_e = 1'b0;
  bit   m_gt = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, r;
    int     sel;
    sa  = $signed(a);
    sb  = $signed(b);
    sel = -1;
    for (int i = 0; i < 15; i++) if (c[i] && sel < 0) sel = i;
    r = 0;
    case (sel)
      0, 13, 14: r = sa + sb;
      1:  r = sa - sb;
      3:  r = sa * sb;
      4:  r = (b == 0) ? 0 : sa / sb;
      5:  r = (b == 0) ? 0 : sa % sb;
      6:  r = a & b;
      7:  r = a | b;
      8:  r = ~a;
      9:  r = b;
      10: r = a << b[4:0];
      11: r = a >> b[4:0];
      12: r = sa >>> b[4:0];
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic step(input logic r, input logic [31:0] p, input logic [31:0] bt,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] o2,
                      input logic [31:0] ins, input logic [31:0] c);
    exp_t        e;
    logic [31:0] exp_br;
    logic        exp_tk;
    @(negedge clk);
    rst = r; pc = p; branchTarget = bt; A = a; B = b; op2 = o2; instruction = ins; control = c;
    #1;
    exp_br = c[18] ? a : bt;
    exp_tk = !r && (c[17] || (c[15] && m_e) || (c[16] && m_gt));
    check("branch", branch, exp_br);
    check("isBranchTaken", {31'b0, isBranchTaken}, {31'b0, exp_tk});
    if (r) begin
      e = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      m_e = 1'b0; m_gt = 1'b0;
    end else begin
      e = '{p, ref_alu(c, a, b), o2, ins, c};
      if (c[2]) begin
        m_e  = (a == b);
        m_gt = ($signed(a) > $signed(b));
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic alu_op(input int bitn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] c;
    c = 32'd1 << bitn;
    step(1'b0, $urandom, $urandom, a, b, $urandom, $urandom, c);
  endtask

  // Monitor: every clock edge retires one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc_out", pc_out, e.pc);
        check("aluResult_out", aluResult_out, e.alu);
        check("op2_out", op2_out, e.op2);
        check("instruction_out", instruction_out, e.instr);
        check("control_out", control_out, e.ctrl);
      end
    end
  end

  initial begin
    logic [31:0] a, b, c;
    // Set flags, then reset with random inputs: outputs and flags must clear.
    step(1'b0, 32'h4, 32'h8, 32'd5, 32'd5, 32'h0, 32'h0, 32'h4);
    step(1'b1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom | 32'h2_0000);
    step(1'b0, 32'h8, 32'h100, 32'd0, 32'd0, 32'h0, 32'h0, 32'h1_8000);
    // Logic ops
    step(1'b0, 32'h18, 32'h0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h1234, 32'h33333333, 32'h40);
    alu_op(7, 32'h0F0F0F0F, 32'hF0F0F0F0);
    step(1'b0, 32'h1C, 32'h0, 32'hAAAAAAAA, 32'h0, 32'hCAFEF00D, 32'h1, 32'h100);
    // Arithmetic corners
    alu_op(0, 32'h7FFFFFFF, 32'h1);
    alu_op(4, 32'hFFFFFFF9, 32'h2);
    alu_op(5, 32'hFFFFFFF9, 32'h2);
    alu_op(4, 32'h12345678, 32'h0);
    alu_op(5, 32'h12345678, 32'h0);
    alu_op(4, 32'h80000000, 32'hFFFFFFFF);
    alu_op(12, 32'h80000000, 32'h4);
    alu_op(11, 32'h80000000, 32'h4);
    alu_op(3, 32'hFFFFFFFD, 32'h7);
    // Compare and branch
    step(1'b0, 32'h20, 32'h0, 32'd5, 32'd5, 32'h0, 32'h0, 32'h4);
    step(1'b0, 32'h24, 32'h100, 32'd0, 32'd0, 32'h0, 32'h0, 32'h8000);
    step(1'b0, 32'h28, 32'h0, 32'd3, 32'd5, 32'h0, 32'h0, 32'h4);
    step(1'b0, 32'h2C, 32'h100, 32'd0, 32'd0, 32'h0, 32'h0, 32'h1_0000);
    // Cmp + beq together uses the old flags
    step(1'b0, 32'h30, 32'h0, 32'd7, 32'd7, 32'h0, 32'h0, 32'h4);
    step(1'b0, 32'h34, 32'h300, 32'd1, 32'd2, 32'h0, 32'h0, 32'h8004);
    step(1'b0, 32'h38, 32'h300, 32'd1, 32'd2, 32'h0, 32'h0, 32'h8000);
    // Ret
    step(1'b0, 32'h3C, 32'h200, 32'h40, 32'h0, 32'h0, 32'h0, 32'h6_0000);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) - 4 : $urandom;
      if ($urandom_range(0, 5) == 0) b = a;
      if ($urandom_range(0, 3) == 0) c = $urandom;
      else c = (32'd1 << $urandom_range(0, 14)) | ($urandom & 32'hFFFF8000);
      step(($urandom_range(0, 39) == 0), $urandom, $urandom, a, b, $urandom, $urandom, c);
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
